// File: rtl/otp_bit_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : otp_bit_serializer_if
//  Description : Handshake/bus bundle between the one-time-pad bit serializer
//                and its plaintext/key source, XOR gate and cipher consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface otp_bit_serializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    // Word intake
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_msg;
    logic [WIDTH-1:0] in_key;
    // Bit-pair stream to / from the XOR gate
    logic             a;
    logic             b;
    logic             bit_valid;
    logic             bit_ready;
    logic             bit_last;
    logic             c;
    // Cipher result
    logic [WIDTH-1:0] cipher_out;
    logic             cipher_valid;
    logic [CNT_W-1:0] word_count;

    // Serializer side
    modport slave (
        input  in_valid, in_msg, in_key, bit_ready, c,
        output in_ready, a, b, bit_valid, bit_last,
               cipher_out, cipher_valid, word_count
    );

    // Source / gate / consumer side
    modport master (
        output in_valid, in_msg, in_key, bit_ready, c,
        input  in_ready, a, b, bit_valid, bit_last,
               cipher_out, cipher_valid, word_count
    );
endinterface
`default_nettype wire

// File: rtl/otp_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : otp_bit_serializer
//  Description : Accepts a plaintext/key word pair, streams it as bit pairs
//                to an external 1-bit XOR gate, reassembles the returned gate
//                outputs into a cipher word and strobes it out.
//                Optional macro LSB_FIRST_EN: stream bits LSB first instead
//                of MSB first (cipher_out bit positions are unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module otp_bit_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    otp_bit_serializer_if.slave   bus
);

    localparam int C_BIT_W = $clog2(WIDTH);
    localparam logic [C_BIT_W-1:0] C_LAST = C_BIT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_msg_sr;
    logic [WIDTH-1:0]   r_key_sr;
    logic [WIDTH-1:0]   r_cipher_sr;
    logic [C_BIT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_cipher_out;
    logic [CNT_W-1:0]   r_word_count;

    logic               w_in_ready;
    logic               w_bit_valid;
    logic               w_bit_last;
    logic               w_a;
    logic               w_b;
    logic               w_cipher_valid;

    logic               w_accept;
    logic               w_xfer;
    logic               w_last;
    logic               w_a_bit;
    logic               w_b_bit;
    logic [WIDTH-1:0]   w_msg_shift;
    logic [WIDTH-1:0]   w_key_shift;
    logic [WIDTH-1:0]   w_cipher_next;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_xfer   = (r_state == S_SHIFT) && bus.bit_ready;
    assign w_last   = (r_bit_cnt == C_LAST);

`ifdef LSB_FIRST_EN
    // LSB-first: shift right, returned bit enters at the top so that after
    // WIDTH transfers every cipher bit sits at its natural position.
    assign w_a_bit       = r_msg_sr[0];
    assign w_b_bit       = r_key_sr[0];
    assign w_msg_shift   = r_msg_sr >> 1;
    assign w_key_shift   = r_key_sr >> 1;
    assign w_cipher_next = (r_cipher_sr >> 1) | {bus.c, {(WIDTH-1){1'b0}}};
`else
    // MSB-first: shift left, returned bit enters at the bottom.
    assign w_a_bit       = r_msg_sr[WIDTH-1];
    assign w_b_bit       = r_key_sr[WIDTH-1];
    assign w_msg_shift   = r_msg_sr << 1;
    assign w_key_shift   = r_key_sr << 1;
    assign w_cipher_next = (r_cipher_sr << 1) | {{(WIDTH-1){1'b0}}, bus.c};
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: EMIT lasts one cycle but may chain straight into SHIFT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_xfer && w_last) w_state_nxt = S_EMIT;
            S_EMIT:  w_state_nxt = w_accept ? S_SHIFT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: a/b are gated so they read 0 whenever no pair is live
    always_comb begin
        w_in_ready     = 1'b0;
        w_bit_valid    = 1'b0;
        w_bit_last     = 1'b0;
        w_a            = 1'b0;
        w_b            = 1'b0;
        w_cipher_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
            end
            S_SHIFT: begin
                w_bit_valid = 1'b1;
                w_bit_last  = w_last;
                w_a         = w_a_bit;
                w_b         = w_b_bit;
            end
            S_EMIT: begin
                w_in_ready     = 1'b1;
                w_cipher_valid = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: latch on acceptance, shift and collect c on each transfer,
    // publish the cipher word and bump the count on the final transfer so
    // both are already valid during the EMIT strobe cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg_sr     <= '0;
            r_key_sr     <= '0;
            r_cipher_sr  <= '0;
            r_bit_cnt    <= '0;
            r_cipher_out <= '0;
            r_word_count <= '0;
        end else if (w_accept) begin
            r_msg_sr    <= bus.in_msg;
            r_key_sr    <= bus.in_key;
            r_cipher_sr <= '0;
            r_bit_cnt   <= '0;
        end else if (w_xfer) begin
            r_msg_sr    <= w_msg_shift;
            r_key_sr    <= w_key_shift;
            r_cipher_sr <= w_cipher_next;
            r_bit_cnt   <= r_bit_cnt + C_BIT_W'(1);
            if (w_last) begin
                r_cipher_out <= w_cipher_next;
                r_word_count <= r_word_count + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.bit_valid    = w_bit_valid;
    assign bus.bit_last     = w_bit_last;
    assign bus.a            = w_a;
    assign bus.b            = w_b;
    assign bus.cipher_valid = w_cipher_valid;
    assign bus.cipher_out   = r_cipher_out;
    assign bus.word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_otp_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otp_bit_serializer
//  Description : Directed bench for otp_bit_serializer with an XOR-gate model
//                on c and a queue scoreboard for bit pairs and cipher words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otp_bit_serializer;

    typedef struct packed {
        logic a;
        logic b;
        logic last;
    } bit_t;

    logic clk;
    logic rst;

    otp_bit_serializer_if #(.WIDTH(8), .CNT_W(16)) bus ();

    otp_bit_serializer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The 1-bit XOR gate being fed
    assign bus.c = bus.a ^ bus.b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         tests;
    int         fails;
    int         n_strobes;
    int         cycle;
    int         last_strobe;
    bit         chk_gap;
    logic [15:0] wc_exp;
    logic [7:0] a_seq;
    logic [7:0] b_seq;
    bit_t       exp_bits[$];
    logic [7:0] exp_cipher[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] msg, input logic [7:0] key);
        bit_t e;
        int   idx;
        for (int i = 0; i < 8; i++) begin
`ifdef LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            e.a    = msg[idx];
            e.b    = key[idx];
            e.last = (i == 7);
            exp_bits.push_back(e);
        end
        exp_cipher.push_back(msg ^ key);
    endtask

    // Offer a pair; returns one cycle after the accepting edge (pair 0 live)
    task automatic offer(input logic [7:0] msg, input logic [7:0] key);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_msg   = msg;
        bus.in_key   = key;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        tests++;
        assert (n < 40) else begin
            fails++;
            $error("FAIL accept_timeout: observed %0d cycles expected <40", n);
        end
        push_word(msg, key);
        step();
        bus.in_valid = 1'b0;
        bus.in_msg   = 8'($urandom);
        bus.in_key   = 8'($urandom);
    endtask

    task automatic wait_strobes(input int target);
        int n;
        n = 0;
        while (n_strobes < target && n < 100) begin
            step();
            n++;
        end
        tests++;
        assert (n < 100) else begin
            fails++;
            $error("FAIL strobe_timeout: observed %0d strobes expected %0d", n_strobes, target);
        end
    endtask

    // Reset asserted mid-cycle, checked before any clock edge
    task automatic rst_pulse();
        #1;
        rst = 1'b1;
        #1;
        check("rst_ctrl", {bus.in_ready, bus.a, bus.b, bus.bit_valid, bus.bit_last, bus.cipher_valid}, 6'b100000);
        check("rst_cipher_out", bus.cipher_out, 8'h00);
        check("rst_word_count", bus.word_count, 16'h0000);
        step();
        rst = 1'b0;
        exp_bits.delete();
        exp_cipher.delete();
        wc_exp = '0;
    endtask

    // Scoreboard monitor: samples mid-cycle, on the values the next edge acts on
    initial begin
        bit_t       e;
        logic [7:0] ec;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst === 1'b0 && bus.bit_valid === 1'b1 && bus.bit_ready === 1'b1) begin
                tests++;
                assert (exp_bits.size() != 0) else begin
                    fails++;
                    $error("FAIL spurious_bit: observed a=%0b b=%0b expected no pair", bus.a, bus.b);
                end
                if (exp_bits.size() != 0) begin
                    e = exp_bits.pop_front();
                    check("bit_a", bus.a, e.a);
                    check("bit_b", bus.b, e.b);
                    check("bit_last", bus.bit_last, e.last);
                    a_seq = {a_seq[6:0], bus.a};
                    b_seq = {b_seq[6:0], bus.b};
                end
            end
            if (rst === 1'b0 && bus.cipher_valid === 1'b1) begin
                tests++;
                assert (exp_cipher.size() != 0) else begin
                    fails++;
                    $error("FAIL spurious_cipher: observed %0h expected no strobe", bus.cipher_out);
                end
                if (exp_cipher.size() != 0) begin
                    ec = exp_cipher.pop_front();
                    check("cipher_out", bus.cipher_out, ec);
                end
                wc_exp = wc_exp + 16'd1;
                check("word_count", bus.word_count, wc_exp);
                if (chk_gap && last_strobe >= 0)
                    check("strobe_gap", cycle - last_strobe, 9);
                last_strobe = cycle;
                n_strobes++;
            end
        end
    end

    initial begin
        logic sa, sb, sl;
        int   base;
        tests = 0; fails = 0; n_strobes = 0; cycle = 0;
        last_strobe = -1; chk_gap = 1'b0; wc_exp = '0;
        a_seq = '0; b_seq = '0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_msg    = '0;
        bus.in_key    = '0;
        bus.bit_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // 1: single word 'g' / 0x34
        rst_pulse();
        base = n_strobes;
        offer(8'h67, 8'h34);
        wait_strobes(base + 1);
        check("t1_cipher", bus.cipher_out, 8'h53);
        check("t1_count", bus.word_count, 16'd1);
`ifdef LSB_FIRST_EN
        check("t1_a_seq", a_seq, 8'hE6);
        check("t1_b_seq", b_seq, 8'h2C);
`else
        check("t1_a_seq", a_seq, 8'h67);
        check("t1_b_seq", b_seq, 8'h34);
`endif
        step();
        check("t1_strobe_one_cycle", bus.cipher_valid, 1'b0);
        check("t1_cipher_hold", bus.cipher_out, 8'h53);

        // 2: back-to-back "galo"
        rst_pulse();
        last_strobe = -1;
        chk_gap = 1'b1;
        base = n_strobes;
        offer(8'h67, 8'h34);
        offer(8'h61, 8'hE0);
        offer(8'h6C, 8'hFC);
        offer(8'h6F, 8'h94);
        wait_strobes(base + 4);
        chk_gap = 1'b0;
        check("t2_count", bus.word_count, 16'd4);
        check("t2_last_cipher", bus.cipher_out, 8'hFB);

        // 3: 3-cycle stall at bit 4
        step();
        base = n_strobes;
        offer(8'h61, 8'hE0);
        for (int i = 0; i < 4; i++) step();
        bus.bit_ready = 1'b0;
        sa = bus.a; sb = bus.b; sl = bus.bit_last;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_ab", {bus.bit_valid, bus.a, bus.b, bus.bit_last}, {1'b1, sa, sb, sl});
        end
        bus.bit_ready = 1'b1;
        wait_strobes(base + 1);
        check("t3_cipher", bus.cipher_out, 8'h81);

        // 5: pair offered during SHIFT is held off until EMIT
        step();
        base = n_strobes;
        offer(8'h67, 8'h34);
        bus.in_valid = 1'b1;
        bus.in_msg   = 8'h6C;
        bus.in_key   = 8'hFC;
        for (int i = 0; i < 8; i++) begin
            check("t5_busy_ready", {bus.in_ready, bus.bit_valid}, 2'b01);
            step();
        end
        check("t5_emit_ready", {bus.in_ready, bus.cipher_valid}, 2'b11);
        push_word(8'h6C, 8'hFC);
        step();
        bus.in_valid = 1'b0;
        wait_strobes(base + 2);
        check("t5_cipher", bus.cipher_out, 8'h90);

        // 4: reset mid-word discards the partial word
        step();
        offer(8'h6C, 8'hFC);
        for (int i = 0; i < 5; i++) step();
        rst_pulse();
        for (int i = 0; i < 3; i++) step();
        base = n_strobes;
        offer(8'h6F, 8'h94);
        wait_strobes(base + 1);
        check("t4_cipher", bus.cipher_out, 8'hFB);
        check("t4_count", bus.word_count, 16'd1);

        // Drain: nothing left outstanding
        for (int i = 0; i < 4; i++) step();
        check("drain_bits", exp_bits.size(), 0);
        check("drain_cipher", exp_cipher.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
